// File: rtl/rect_index_gen_pkg.sv
// Shared types and constants for the rectangle-loop index generator and its consumer stage.
package rect_loop_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRAW_R0,
      DRAW_R1,
      DRAW_C0,
      DRAW_C1,
      PRESENT
   } gen_state_t;

   localparam logic [15:0] LFSR_MASK    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam int unsigned IDX_W        = 16;

   // Wide enough for any supported matrix; consumers slice to their own index width.
   typedef struct packed {
      logic [IDX_W-1:0] row_a;
      logic [IDX_W-1:0] row_b;
      logic [IDX_W-1:0] col_a;
      logic [IDX_W-1:0] col_b;
   } idx_set_t;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
   endfunction

endpackage

// File: rtl/rect_index_gen_if.sv
// Valid/ready index-set channel from the generator to the rectangle-loop stage.
interface rect_index_gen_if #(
   parameter int unsigned ROW_W = 1,
   parameter int unsigned COL_W = 1
) ();
   logic             idx_valid;
   logic             idx_ready;
   logic [ROW_W-1:0] row_a;
   logic [ROW_W-1:0] row_b;
   logic [COL_W-1:0] col_a;
   logic [COL_W-1:0] col_b;
   logic             last;

   modport master (
      output idx_valid, row_a, row_b, col_a, col_b, last,
      input  idx_ready
   );

   modport slave (
      input  idx_valid, row_a, row_b, col_a, col_b, last,
      output idx_ready
   );
endinterface

// File: rtl/rect_index_gen_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load; a zero load value falls back to SEED.
module lfsr16
   import rect_loop_pkg::*;
#(
   parameter logic [15:0] SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic [15:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= SEED;
      end else if (load) begin
         q <= (load_val == '0) ? SEED : load_val;
      end else if (en) begin
         q <= lfsr_step(q);
      end
   end

endmodule

// File: rtl/rect_index_gen.sv
// Draws distinct row/column index pairs by LFSR rejection sampling and hands them out over valid/ready.
module rect_index_gen
   import rect_loop_pkg::*;
#(
   parameter int unsigned       MATRIX_ROW = 2,
   parameter int unsigned       MATRIX_COL = 2,
   parameter int unsigned       LFSR_W     = 16,
   parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED,
   parameter int unsigned       ITER_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ITER_W-1:0] n_iter,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
   rect_index_gen_if.master  idx,
   output logic              busy,
   output logic              done
);

   localparam int unsigned ROW_W = (MATRIX_ROW > 2) ? $clog2(MATRIX_ROW) : 1;
   localparam int unsigned COL_W = (MATRIX_COL > 2) ? $clog2(MATRIX_COL) : 1;

   gen_state_t        state;
   logic [ITER_W-1:0] remaining;
   logic [ROW_W-1:0]  row_a_q, row_b_q;
   logic [COL_W-1:0]  col_a_q, col_b_q;
   logic              valid_q, last_q;

   logic [15:0]       lfsr_q;
   logic              lfsr_en, lfsr_load;
   logic              lfsr_unused;
   logic [ROW_W-1:0]  row_s;
   logic [COL_W-1:0]  col_s;
   logic              row_ok, col_ok;

   assign lfsr_en   = (state == DRAW_R0) || (state == DRAW_R1) ||
                      (state == DRAW_C0) || (state == DRAW_C1);
   assign lfsr_load = (state == IDLE) && seed_load;

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .en       (lfsr_en),
      .load     (lfsr_load),
      .load_val (seed_in),
      .q        (lfsr_q)
   );

   // Samples are taken from the pre-step value; only the low bits matter here.
   assign row_s       = lfsr_q[ROW_W-1:0];
   assign col_s       = lfsr_q[COL_W-1:0];
   assign row_ok      = 32'(row_s) < MATRIX_ROW;
   assign col_ok      = 32'(col_s) < MATRIX_COL;
   assign lfsr_unused = ^lfsr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         row_a_q   <= '0;
         row_b_q   <= '0;
         col_a_q   <= '0;
         col_b_q   <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (n_iter != '0) begin
                     remaining <= n_iter;
                     busy      <= 1'b1;
                     state     <= DRAW_R0;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            DRAW_R0: begin
               if (row_ok) begin
                  row_a_q <= row_s;
                  state   <= DRAW_R1;
               end
            end
            DRAW_R1: begin
               if (row_ok && (row_s != row_a_q)) begin
                  row_b_q <= row_s;
                  state   <= DRAW_C0;
               end
            end
            DRAW_C0: begin
               if (col_ok) begin
                  col_a_q <= col_s;
                  state   <= DRAW_C1;
               end
            end
            DRAW_C1: begin
               if (col_ok && (col_s != col_a_q)) begin
                  col_b_q <= col_s;
                  valid_q <= 1'b1;
                  last_q  <= (remaining == ITER_W'(1));
                  state   <= PRESENT;
               end
            end
            PRESENT: begin
               if (idx.idx_ready) begin
                  valid_q   <= 1'b0;
                  last_q    <= 1'b0;
                  remaining <= remaining - ITER_W'(1);
                  if (remaining == ITER_W'(1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     state <= DRAW_R0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign idx.idx_valid = valid_q;
   assign idx.last      = last_q;
   assign idx.row_a     = row_a_q;
   assign idx.row_b     = row_b_q;
   assign idx.col_a     = col_a_q;
   assign idx.col_b     = col_b_q;

endmodule

// File: tb/tb_rect_index_gen.sv
// Randomized bench for rect_index_gen: a 3x5 instance against a sampling model, plus a 4x4 directed case.
module tb_rect_index_gen;
   import rect_loop_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start_a, seed_load_a, busy_a, done_a;
   logic [15:0] n_iter_a, seed_in_a;
   rect_index_gen_if #(.ROW_W(2), .COL_W(3)) idx_a ();

   rect_index_gen #(.MATRIX_ROW(3), .MATRIX_COL(5)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .start     (start_a),
      .n_iter    (n_iter_a),
      .seed_load (seed_load_a),
      .seed_in   (seed_in_a),
      .idx       (idx_a.master),
      .busy      (busy_a),
      .done      (done_a)
   );

   logic        start_b, seed_load_b, busy_b, done_b;
   logic [15:0] n_iter_b, seed_in_b;
   rect_index_gen_if #(.ROW_W(2), .COL_W(2)) idx_b ();

   rect_index_gen #(.MATRIX_ROW(4), .MATRIX_COL(4)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .start     (start_b),
      .n_iter    (n_iter_b),
      .seed_load (seed_load_b),
      .seed_in   (seed_in_b),
      .idx       (idx_b.master),
      .busy      (busy_b),
      .done      (done_b)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: plain rejection sampling over the polynomial sequence.
   logic [15:0] m_lfsr;
   int unsigned m_nc;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      logic [15:0] r;
      r = v >> 1;
      if (v[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   function automatic int unsigned draw(input int unsigned lim, input int excl);
      int unsigned w, s;
      w = (lim <= 2) ? 1 : $clog2(lim);
      do begin
         s      = int'(m_lfsr) % (1 << w);
         m_lfsr = lfsr_next(m_lfsr);
         m_nc++;
      end while (!(s < lim && int'(s) != excl));
      return s;
   endfunction

   task automatic next_set(output idx_set_t e, output int unsigned nc);
      m_nc    = 0;
      e.row_a = 16'(draw(3, -1));
      e.row_b = 16'(draw(3, int'(e.row_a)));
      e.col_a = 16'(draw(5, -1));
      e.col_b = 16'(draw(5, int'(e.col_a)));
      nc      = m_nc;
   endtask

   task automatic check_zero_a(input string tag);
      check({tag, "_valid"}, idx_a.idx_valid, 0);
      check({tag, "_last"},  idx_a.last, 0);
      check({tag, "_busy"},  busy_a, 0);
      check({tag, "_done"},  done_a, 0);
      check({tag, "_row_a"}, idx_a.row_a, 0);
      check({tag, "_row_b"}, idx_a.row_b, 0);
      check({tag, "_col_a"}, idx_a.col_a, 0);
      check({tag, "_col_b"}, idx_a.col_b, 0);
   endtask

   // mode 0: random ready with stray starts, 1: ready always, 2: ready held low 20 cycles
   task automatic run_a(input int unsigned n, input int mode, input bit do_seed, input logic [15:0] seed);
      int unsigned hs, wait_cyc, guard, stall, nc;
      bit          seen, r;
      idx_set_t    e;
      @(negedge clk);
      start_a = 1'b1; n_iter_a = 16'(n); seed_load_a = do_seed; seed_in_a = seed;
      idx_a.idx_ready = 1'b0;
      if (do_seed) m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
      next_set(e, nc);
      @(negedge clk);
      start_a = 1'b0; seed_load_a = 1'b0;
      hs = 0; wait_cyc = 1; seen = 1'b0; guard = 0; stall = 0;
      while (hs < n && guard < 30000) begin
         check("run_busy", busy_a, 1);
         check("run_done", done_a, 0);
         if (idx_a.idx_valid) begin
            if (!seen) begin
               check("latency", wait_cyc, nc + 1);
               seen = 1'b1;
            end
            check("row_a", idx_a.row_a, e.row_a);
            check("row_b", idx_a.row_b, e.row_b);
            check("col_a", idx_a.col_a, e.col_a);
            check("col_b", idx_a.col_b, e.col_b);
            check("last",  idx_a.last, (hs == n - 1) ? 1 : 0);
            check("lfsr_hold", dut_a.u_lfsr.q, m_lfsr);
            case (mode)
               0:       r = 1'($urandom_range(0, 1));
               1:       r = 1'b1;
               default: r = (stall >= 20);
            endcase
            stall++;
            idx_a.idx_ready = r;
            if (r) begin
               hs++; seen = 1'b0; wait_cyc = 0; stall = 0;
               if (hs < n) next_set(e, nc);
            end
         end else begin
            idx_a.idx_ready = 1'($urandom_range(0, 1));
         end
         n_iter_a = 16'd7;
         start_a  = (mode == 0 && hs < n) ? ($urandom_range(0, 3) == 0) : 1'b0;
         @(negedge clk);
         wait_cyc++; guard++;
      end
      start_a = 1'b0; idx_a.idx_ready = 1'b0;
      check("handshakes", hs, n);
      check("done_pulse", done_a, 1);
      check("busy_after", busy_a, 0);
      check("valid_after", idx_a.idx_valid, 0);
      @(negedge clk);
      check("done_single", done_a, 0);
   endtask

   initial begin
      int unsigned cyc;
      logic [15:0] s;
      rst = 1'b1;
      start_a = 1'b0; seed_load_a = 1'b0; n_iter_a = '0; seed_in_a = '0; idx_a.idx_ready = 1'b0;
      start_b = 1'b0; seed_load_b = 1'b0; n_iter_b = '0; seed_in_b = '0; idx_b.idx_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_zero_a("rst");
      check("rst_lfsr", dut_a.u_lfsr.q, 16'hACE1);
      check("rst_b_valid", idx_b.idx_valid, 0);
      check("rst_b_busy", busy_b, 0);
      m_lfsr = 16'hACE1;

      // 4x4 directed: one rejection in the last column draw
      @(negedge clk);
      start_b = 1'b1; n_iter_b = 16'd1; idx_b.idx_ready = 1'b1;
      @(negedge clk);
      start_b = 1'b0; cyc = 1;
      while (!idx_b.idx_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("b_latency", cyc, 6);
      check("b_row_a", idx_b.row_a, 1);
      check("b_row_b", idx_b.row_b, 0);
      check("b_col_a", idx_b.col_a, 0);
      check("b_col_b", idx_b.col_b, 2);
      check("b_last",  idx_b.last, 1);
      check("b_busy",  busy_b, 1);
      @(negedge clk);
      idx_b.idx_ready = 1'b0;
      check("b_done", done_b, 1);
      check("b_busy_done", busy_b, 0);
      check("b_valid_done", idx_b.idx_valid, 0);
      @(negedge clk);
      check("b_done_single", done_b, 0);

      run_a(1000, 0, 1'b0, 16'h0);
      run_a(1, 2, 1'b0, 16'h0);

      // zero-length run
      @(negedge clk);
      start_a = 1'b1; n_iter_a = 16'd0;
      @(negedge clk);
      start_a = 1'b0;
      check("zero_done", done_a, 1);
      check("zero_busy", busy_a, 0);
      check("zero_valid", idx_a.idx_valid, 0);
      @(negedge clk);
      check("zero_done_single", done_a, 0);
      check("zero_busy2", busy_a, 0);

      // seed loads
      @(negedge clk);
      seed_load_a = 1'b1; seed_in_a = 16'h0;
      @(negedge clk);
      seed_load_a = 1'b0;
      check("seed_zero", dut_a.u_lfsr.q, 16'hACE1);
      s = 16'($urandom_range(1, 65535));
      seed_load_a = 1'b1; seed_in_a = s;
      @(negedge clk);
      seed_load_a = 1'b0;
      check("seed_load", dut_a.u_lfsr.q, s);
      m_lfsr = s;
      run_a(5, 1, 1'b0, 16'h0);
      run_a(5, 0, 1'b1, s);

      // reset mid-DRAW
      @(negedge clk);
      start_a = 1'b1; n_iter_a = 16'd3;
      @(negedge clk);
      start_a = 1'b0;
      check("pre_rst_busy", busy_a, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_zero_a("rst_draw");
      check("rst_draw_lfsr", dut_a.u_lfsr.q, 16'hACE1);
      @(negedge clk);
      check("rst_draw_nodone", done_a, 0);

      // reset mid-PRESENT
      start_a = 1'b1; n_iter_a = 16'd3; idx_a.idx_ready = 1'b0;
      @(negedge clk);
      start_a = 1'b0; cyc = 0;
      while (!idx_a.idx_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("present_reached", idx_a.idx_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_zero_a("rst_present");
      check("rst_present_lfsr", dut_a.u_lfsr.q, 16'hACE1);
      @(negedge clk);
      check("rst_present_nodone", done_a, 0);
      m_lfsr = 16'hACE1;
      run_a(3, 1, 1'b0, 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
